accum_multi: RTL
================

# accum_multi

Parametrised multi-channel accumulator, the next generation of the single-channel data/enable/clear/accum block. It keeps NUM_CH independent running sums and accepts one input beat per cycle on a valid/ready handshake, each beat tagged with a channel. After every accepted beat it emits the updated sum on a registered valid/ready output port. It sits between the stimulus/data path and downstream consumers, and reports per-channel overflow.

## Interface
- DATA_W, 32: input data width, unsigned.
- ACC_W, 40: accumulator and result width; must be >= DATA_W.
- NUM_CH, 4: number of channels, >= 2.
- CH_W, $clog2(NUM_CH): derived channel-index width; do not override.
- clk  in  1  sole clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block can accept a beat.
- in_ch  in  CH_W  target channel; values >= NUM_CH are dropped (beat accepted, no effect, no output).
- in_data  in  DATA_W  addend, zero-extended to ACC_W.
- clear  in  NUM_CH  per-channel synchronous clear mask.
- out_valid  out  1  out_ch/out_accum hold a result.
- out_ready  in  1  consumer takes the result.
- out_ch  out  CH_W  channel of the presented result.
- out_accum  out  ACC_W  updated sum after the beat.
- ovf  out  NUM_CH  sticky per-channel overflow flags.

## Operation
- Beat accepted when in_valid && in_ready. in_ready = !out_valid || out_ready (combinational; one-deep output register, no skid buffer).
- Accepted beat on channel c: next = base + in_data. base = 0 if clear[c] is set that cycle, else acc[c]. Write next to acc[c], out_accum, and out_ch; set out_valid.
- Carry out of ACC_W on the add sets ovf[c]. Result per Configuration.
- clear[c] without a beat to c: acc[c] <= 0, ovf[c] <= 0. A clear with a same-cycle beat to c clears ovf[c] first; an overflow on that beat then sets it again.
- Multiple clear bits may be set in one cycle; each acts independently.
- The output register is a snapshot. A later clear of that channel does not alter a stalled out_accum.
- out_valid clears when out_valid && out_ready and no new beat is accepted that cycle. Accept and drain in the same cycle reloads the register and keeps out_valid high.
- While out_valid && !out_ready, the output fields hold stable and no beats are accepted. clear still acts on the accumulators.

## Timing
- Reset (asynchronous, any cycle): all acc = 0, out_valid = 0, out_ch = 0, out_accum = 0, ovf = 0. in_ready = 1 while reset is asserted and after release. A result pending at reset is discarded.
- Latency: beat accepted at edge N gives out_valid with the result after edge N (visible in cycle N+1).
- Throughput: one beat per cycle while out_ready = 1.
- ovf updates at the same edge as the corresponding result.
- Back-to-back beats to the same channel chain correctly: each beat sees the previous beat's write, with no hazard bubble.

## Configuration
- ACCUM_SAT_EN defined: on carry out, acc[c] and out_accum are clamped to 2^ACC_W-1. Subsequent beats stay saturated until clear.
- ACCUM_SAT_EN undefined: the sum wraps modulo 2^ACC_W.
- ovf behaves identically in both builds.

## Test plan
- Reset then beats ch0: 5, 7, 3 with out_ready = 1 -> out_accum 5, 12, 15 on consecutive cycles, out_ch = 0, ovf = 0.
- Interleave ch1 += 100 and ch2 += 1, four beats each, alternating -> final ch1 = 400, ch2 = 4. Channels stay independent and are tagged correctly.
- Hold out_ready = 0 after one beat -> in_ready = 0, out fields stable for 10 cycles. Release -> next beat accepted that same cycle, so the drain and the new beat share one edge.
- Clear and add in one cycle: ch3 holds 50, then clear[3] = 1 with an in_ch = 3 beat of data 9 -> out_accum = 9. The next beat of 1 gives 10.
- ACC_W = DATA_W = 8, ch0: 200 + 100 -> ovf[0] = 1. Result 255 with ACCUM_SAT_EN defined, 44 without. clear[0] -> ovf[0] = 0, acc = 0.
- Assert reset mid-stall with out_valid = 1 -> out_valid = 0, all sums 0, in_ready = 1. The first post-reset beat of 4 yields 4.

Source files
------------

// File: rtl/accum_multi.sv
// Multi-channel running-sum accumulator with valid/ready in and a one-deep registered result.
// Optional build macro ACCUM_SAT_EN: clamp sums to all-ones on carry instead of wrapping.
module accum_multi #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 40,
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0] clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic [ACC_W-1:0]  out_accum,
  output logic [NUM_CH-1:0] ovf
);

  logic [ACC_W-1:0]  acc [NUM_CH];
  logic [NUM_CH-1:0] ovf_q;

  logic              vld_p1;
  logic [CH_W-1:0]   ch_p1;
  logic [ACC_W-1:0]  accum_p1;

  logic [ACC_W-1:0]  base_p0;
  logic [ACC_W:0]    sum_p0;
  logic [ACC_W-1:0]  result_p0;
  logic              carry_p0;
  logic [NUM_CH-1:0] hit_p0;
  logic              take_p0;

  function automatic logic [ACC_W-1:0] sat_result(input logic [ACC_W:0] s);
`ifdef ACCUM_SAT_EN
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
`else
    return s[ACC_W-1:0];
`endif
  endfunction

  assign in_ready = !vld_p1 || out_ready;

  // Stage p0: channel decode, clear-aware base select and add
  always_comb begin
    base_p0 = '0;
    hit_p0  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (in_ch == CH_W'(i)) begin
        hit_p0[i] = in_valid && in_ready;
        base_p0   = clear[i] ? '0 : acc[i];
      end
    end
    sum_p0    = {1'b0, base_p0} + (ACC_W+1)'(in_data);
    carry_p0  = sum_p0[ACC_W];
    result_p0 = sat_result(sum_p0);
    // out-of-range channels match no bit, so the beat is consumed silently
    take_p0   = |hit_p0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (hit_p0[i]) begin
          acc[i]   <= result_p0;
          ovf_q[i] <= (ovf_q[i] & ~clear[i]) | carry_p0;
        end else if (clear[i]) begin
          acc[i]   <= '0;
          ovf_q[i] <= 1'b0;
        end
      end
    end
  end

  // Stage p1: result snapshot register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      ch_p1    <= '0;
      accum_p1 <= '0;
    end else if (take_p0) begin
      vld_p1   <= 1'b1;
      ch_p1    <= in_ch;
      accum_p1 <= result_p0;
    end else if (out_ready) begin
      vld_p1   <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_ch    = ch_p1;
  assign out_accum = accum_p1;
  assign ovf       = ovf_q;

endmodule
